// File: rtl/regfile_write_demux.sv
// Register file write side: one-hot address decode, data demux into
// DEPTH storage registers, and two combinational read ports.
module regfile_write_demux #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_TOP = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic [DEPTH-1:0]  wr_onehot,
    output logic              wr_done
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] enable;
    logic [DEPTH-1:0] enable_m;

    // wr_en gates every compare, so an unknown wr_addr while idle
    // never reaches the register enables.
    always_comb begin
        enable = '0;
        for (int i = 0; i < DEPTH; i++) begin
            enable[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    always_comb begin
        enable_m = enable;
        if (ZERO_TOP) begin
            enable_m[DEPTH-1] = 1'b0;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                regs[g] <= '0;
            end else if (enable_m[g]) begin
                regs[g] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_onehot <= '0;
            wr_done   <= 1'b0;
        end else begin
            wr_onehot <= enable_m;
            wr_done   <= |enable_m;
        end
    end

    // No bypass: a same-cycle write is only visible after the edge.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (ZERO_TOP && rd_addr_a == TOP_ADDR) begin
            rd_data_a = '0;
        end
        if (ZERO_TOP && rd_addr_b == TOP_ADDR) begin
            rd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_demux.sv
// Scoreboard bench for regfile_write_demux: directed scenarios plus
// random traffic checked against an array model of the register file.
module tb_regfile_write_demux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [31:0] wr_onehot;
    logic        wr_done;

    regfile_write_demux #(
        .WIDTH(64), .DEPTH(32), .ADDR_W(5), .ZERO_TOP(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .wr_onehot(wr_onehot),
        .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] oh;
        logic        done;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mem [32];
    logic [31:0] m_oh;
    logic        m_done;
    int          tests;
    int          fails;

    function automatic logic [63:0] model_rd(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : mem[a];
    endfunction

    task automatic step(input logic rst, input logic en,
                        input logic [4:0] addr, input logic [63:0] data,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input bit chk);
        exp_t e;
        reset_n   = !rst;
        wr_en     = en;
        wr_addr   = addr;
        wr_data   = data;
        rd_addr_a = ra;
        rd_addr_b = rb;
        if (chk) begin
            e.a    = model_rd(ra);
            e.b    = model_rd(rb);
            e.oh   = m_oh;
            e.done = m_done;
            q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            foreach (mem[i]) mem[i] = '0;
            m_oh   = '0;
            m_done = 1'b0;
        end else if (en && addr != 5'd31) begin
            mem[addr] = data;
            m_oh      = 32'd1 << addr;
            m_done    = 1'b1;
        end else begin
            m_oh   = '0;
            m_done = 1'b0;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [63:0] data,
                      input logic [4:0] ra);
        step(1'b0, 1'b1, addr, data, ra, ra, 1'b1);
    endtask

    task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
        step(1'b0, 1'b0, 5'bx, 64'd0, ra, rb, 1'b1);
    endtask

    // Monitor: one expected entry per observed cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                tests += 4;
                if (rd_data_a !== e.a) begin
                    fails++;
                    $display("FAIL rd_data_a addr=%0d got=%h exp=%h",
                             rd_addr_a, rd_data_a, e.a);
                end
                if (rd_data_b !== e.b) begin
                    fails++;
                    $display("FAIL rd_data_b addr=%0d got=%h exp=%h",
                             rd_addr_b, rd_data_b, e.b);
                end
                if (wr_onehot !== e.oh) begin
                    fails++;
                    $display("FAIL wr_onehot got=%h exp=%h",
                             wr_onehot, e.oh);
                end
                if (wr_done !== e.done) begin
                    fails++;
                    $display("FAIL wr_done got=%b exp=%b",
                             wr_done, e.done);
                end
            end
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        m_oh   = '0;
        m_done = 1'b0;
        foreach (mem[i]) mem[i] = '0;

        // Power-up reset; DUT state is unknown before the first edge.
        step(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd5, 1'b1);
        rd(5'd0, 5'd31);

        // Reset clears previously written registers.
        for (int i = 0; i < 5; i++) begin
            wr(5'(i + 1), 64'h1234_0000_0000_0000 | 64'(i + 1), 5'(i));
        end
        rd(5'd1, 5'd5);
        step(1'b1, 1'b0, 5'd0, 64'd0, 5'd2, 5'd4, 1'b1);
        for (int i = 0; i < 6; i++) rd(5'(i), 5'(5 - i));

        // Single write, one-hot and done follow one cycle later.
        wr(5'd3, 64'hDEAD_BEEF_0000_0001, 5'd3);
        rd(5'd3, 5'd2);
        rd(5'd3, 5'd4);

        // Same-cycle read sees the old value.
        wr(5'd7, 64'hAAAA_5555_0000_0007, 5'd7);
        wr(5'd7, 64'h0123_4567_89AB_CDEF, 5'd7);
        rd(5'd7, 5'd7);

        // Zero register discards writes and never signals done.
        wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
        rd(5'd31, 5'd31);

        // Walk every writable register, then read back idle.
        for (int i = 0; i < 31; i++) begin
            wr(5'(i), 64'(i) * 64'h0101, 5'(i));
        end
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));

        // Reset beats a same-edge write.
        wr(5'd2, 64'h2222, 5'd2);
        step(1'b1, 1'b1, 5'd2, 64'hBAD0_BAD0, 5'd2, 5'd2, 1'b1);
        rd(5'd2, 5'd3);

        // Random traffic, including unknown address while idle.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        en;
            logic [4:0]  a;
            logic [63:0] d;
            r  = ($urandom_range(0, 49) == 0);
            en = $urandom_range(0, 3) != 0;
            a  = 5'($urandom);
            if (!en && $urandom_range(0, 1) == 1) a = 5'bx;
            d  = {$urandom, $urandom};
            step(r, en, a, d, 5'($urandom), 5'($urandom), 1'b1);
        end
        rd(5'd0, 5'd1);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
